// File: rtl/avmm_memory_arbiter_if.sv
// Shared data-width package plus the requester-side and memory-side bus
// bundles used by avmm_memory_arbiter.
package avmm_memory_pkg;
   localparam int DATA_WIDTH          = 512;
   localparam int DATA_WIDTH_IN_BYTES = DATA_WIDTH / 8;
endpackage

interface avmm_arb_req_if #(parameter int NUM_REQ = 4);
   logic [NUM_REQ-1:0]                                             read;
   logic [NUM_REQ-1:0]                                             write;
   logic [NUM_REQ-1:0][51:6]                                       address;
   logic [NUM_REQ-1:0][avmm_memory_pkg::DATA_WIDTH_IN_BYTES-1:0]   byteenable;
   logic [NUM_REQ-1:0][avmm_memory_pkg::DATA_WIDTH-1:0]            writedata;
   logic [NUM_REQ-1:0]                                             grant;
   logic [avmm_memory_pkg::DATA_WIDTH-1:0]                         readdata;
   logic [NUM_REQ-1:0]                                             readdatavalid;

   modport master (output read, write, address, byteenable, writedata,
                   input  grant, readdata, readdatavalid);
   modport slave  (input  read, write, address, byteenable, writedata,
                   output grant, readdata, readdatavalid);
endinterface

interface avmm_arb_mem_if;
   logic                                          read;
   logic                                          write;
   logic [51:6]                                   address;
   logic [avmm_memory_pkg::DATA_WIDTH_IN_BYTES-1:0] byteenable;
   logic [avmm_memory_pkg::DATA_WIDTH-1:0]        writedata;
   logic                                          ready;
   logic [avmm_memory_pkg::DATA_WIDTH-1:0]        readdata;
   logic                                          readdatavalid;

   modport master (output read, write, address, byteenable, writedata,
                   input  ready, readdata, readdatavalid);
   modport slave  (input  read, write, address, byteenable, writedata,
                   output ready, readdata, readdatavalid);
endinterface

// File: rtl/avmm_memory_arbiter.sv
// Round-robin arbiter sharing one AVMM memory port between NUM_REQ requesters;
// a tag FIFO routes in-order read responses back to the issuing requester.
module avmm_memory_arbiter
   import avmm_memory_pkg::*;
#(
   parameter int NUM_REQ         = 4,
   parameter int MAX_OUTSTANDING = 64
) (
   input  logic                               clk,
   input  logic                               rst,
   avmm_arb_req_if.slave                      req,
   avmm_arb_mem_if.master                     mem,
   output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
   output logic                               err_rw_conflict,
   output logic                               err_unexpected_rsp
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
   localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

   logic [IDX_W-1:0] last_r;
   logic [IDX_W-1:0] tag_mem_r [MAX_OUTSTANDING];
   logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
   logic [CNT_W-1:0] count_r;

   logic               tag_full_s, tag_empty_s, arb_en_s, found_s;
   logic [NUM_REQ-1:0] eligible_s, grant_s;
   logic [IDX_W-1:0]   grant_idx_s, head_s;
   logic               sel_read_s, grant_read_s, grant_write_s, conflict_s;
   logic               push_s, pop_s, unexpected_s;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
         ptr_inc = {PTR_W{1'b0}};
      end else begin
         ptr_inc = p + PTR_W'(1);
      end
   endfunction

   assign tag_full_s  = (count_r == CNT_W'(MAX_OUTSTANDING));
   assign tag_empty_s = (count_r == {CNT_W{1'b0}});
   assign arb_en_s    = ~rst & mem.ready;
   // A read-and-write request issues as a read, so it stalls on a full tag FIFO too.
   assign eligible_s  = (req.read & {NUM_REQ{~tag_full_s}}) | (req.write & ~req.read);

   // Round-robin search starting one past the last granted requester.
   always_comb begin
      int               cand;
      logic [IDX_W-1:0] cand_idx;
      cand        = 0;
      cand_idx    = {IDX_W{1'b0}};
      found_s     = 1'b0;
      grant_idx_s = last_r;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand     = (int'(last_r) + k) % NUM_REQ;
         cand_idx = cand[IDX_W-1:0];
         if (arb_en_s && !found_s && eligible_s[cand_idx]) begin
            found_s     = 1'b1;
            grant_idx_s = cand_idx;
         end else begin
            found_s     = found_s;
         end
      end
   end

   assign grant_s       = found_s ? (ONE_HOT_0 << grant_idx_s) : {NUM_REQ{1'b0}};
   assign sel_read_s    = req.read[grant_idx_s];
   assign grant_read_s  = found_s & sel_read_s;
   assign grant_write_s = found_s & req.write[grant_idx_s] & ~sel_read_s;
   assign conflict_s    = found_s & sel_read_s & req.write[grant_idx_s];

   assign push_s        = grant_read_s;
   assign pop_s         = mem.readdatavalid & ~tag_empty_s & ~rst;
   assign unexpected_s  = mem.readdatavalid & tag_empty_s & ~rst;
   assign head_s        = tag_mem_r[rd_ptr_r];

   assign req.grant         = grant_s;
   assign req.readdata      = mem.readdata;
   assign req.readdatavalid = pop_s ? (ONE_HOT_0 << head_s) : {NUM_REQ{1'b0}};
   assign outstanding       = count_r;

   // Tag storage; validity is tracked by the pointers and count alone.
   always_ff @(posedge clk) begin
      if (push_s) begin
         tag_mem_r[wr_ptr_r] <= grant_idx_s;
      end
   end

   // Arbitration state, command register, tag pointers/count and sticky errors.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_r             <= IDX_W'(NUM_REQ - 1);
         mem.read           <= 1'b0;
         mem.write          <= 1'b0;
         mem.address        <= 46'h0;
         mem.byteenable     <= {DATA_WIDTH_IN_BYTES{1'b0}};
         mem.writedata      <= {DATA_WIDTH{1'b0}};
         wr_ptr_r           <= {PTR_W{1'b0}};
         rd_ptr_r           <= {PTR_W{1'b0}};
         count_r            <= {CNT_W{1'b0}};
         err_rw_conflict    <= 1'b0;
         err_unexpected_rsp <= 1'b0;
      end else begin
         mem.read  <= grant_read_s;
         mem.write <= grant_write_s;
         if (found_s) begin
            last_r         <= grant_idx_s;
            mem.address    <= req.address[grant_idx_s];
            mem.byteenable <= req.byteenable[grant_idx_s];
            mem.writedata  <= req.writedata[grant_idx_s];
         end
         if (push_s) begin
            wr_ptr_r <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
         err_rw_conflict    <= err_rw_conflict | conflict_s;
         err_unexpected_rsp <= err_unexpected_rsp | unexpected_s;
      end
   end
endmodule
